// File: rtl/c3lib_rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// c3lib_rr_arb_pkg
//   Shared types and helpers for the round-robin request/ack splitter family.
//   - rr_state_e : handshake FSM encoding (IDLE, REQ, GRANT, REL)
//   - rr_pick()  : rotating first-set search over up to RR_MAX_CLI requestors
// ---------------------------------------------------------------------------
package c3lib_rr_arb_pkg;

  localparam int unsigned RR_MAX_CLI = 16;
  localparam int unsigned RR_PTR_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    GRANT = 2'd2,
    REL   = 2'd3
  } rr_state_e;

  // Returns {found, idx}. Scans req starting at ptr upward and wraps at n,
  // i.e. rotate by ptr, priority-encode from bit 0, then unrotate. Only the
  // low n bits of req take part; ptr is expected to be < n.
  function automatic logic [RR_PTR_W:0] rr_pick(
    input logic [RR_MAX_CLI-1:0] req,
    input logic [RR_PTR_W-1:0]   ptr,
    input int unsigned           n
  );
    logic                found;
    logic [RR_PTR_W-1:0] idx;
    logic [RR_PTR_W:0]   j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < RR_MAX_CLI; i++) begin
      // ptr + i < 2n, so a single conditional subtract is the modulo
      j = {1'b0, ptr} + (RR_PTR_W+1)'(i);
      if (j >= (RR_PTR_W+1)'(n)) j = j - (RR_PTR_W+1)'(n);
      if ((i < n) && !found && req[j[RR_PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = j[RR_PTR_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/c3lib_rr_pick.sv
// ---------------------------------------------------------------------------
// c3lib_rr_pick
//   Combinational round-robin picker: first set request at or above ptr_i,
//   wrapping at NUM_CLI. Thin wrapper around rr_pick() so other arbiters can
//   drop it in with their own widths.
// Ports
//   req_i  [NUM_CLI-1:0]  request vector
//   ptr_i  [IW-1:0]       search start index (< NUM_CLI)
//   idx_o  [IW-1:0]       selected index (0 when nothing requested)
//   vld_o                 at least one request present
// ---------------------------------------------------------------------------
module c3lib_rr_pick
  import c3lib_rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CLI = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_CLI-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [IW-1:0]      idx_o,
  output logic               vld_o
);

  logic [RR_PTR_W:0] pick;

  always_comb begin
    pick  = rr_pick(RR_MAX_CLI'(req_i), RR_PTR_W'(ptr_i), NUM_CLI);
    idx_o = IW'(pick[RR_PTR_W-1:0]);
    vld_o = pick[RR_PTR_W];
  end

endmodule

// File: rtl/c3lib_rr_arb_split.sv
// ---------------------------------------------------------------------------
// c3lib_rr_arb_split
//   Splits one upstream 4-phase req/ack channel across NUM_CLI clients.
//   up_req is the serialised OR of client requests; the returning up_ack is
//   routed as a level grant to exactly one client, chosen round-robin.
//   All outputs are registered; each is decoded from the next FSM state.
//
// Optional feature (macro C3LIB_RR_ARB_TIMEOUT_EN):
//   watchdog counting cycles spent in REQ/REL; at TO_CYCLES it sets sticky
//   to_err, drops up_req/cli_gnt and forces IDLE with the pointer advanced.
//   Without the macro there is no counter and to_err is tied 0.
//
// Ports
//   clk       clock
//   rst_n     async active-low reset
//   cli_req   [NUM_CLI-1:0] level request per client
//   cli_gnt   [NUM_CLI-1:0] one-hot level grant
//   up_req    merged upstream request
//   up_ack    upstream acknowledge
//   owner_id  index of current/last owner
//   busy      FSM not in IDLE
//   to_err    sticky watchdog flag
// ---------------------------------------------------------------------------
module c3lib_rr_arb_split
  import c3lib_rr_arb_pkg::*;
#(
  parameter int unsigned NUM_CLI   = 4,
  parameter int unsigned TO_CYCLES = 255,
  localparam int unsigned IW       = (NUM_CLI > 1) ? $clog2(NUM_CLI) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CLI-1:0] cli_req,
  output logic [NUM_CLI-1:0] cli_gnt,
  output logic               up_req,
  input  logic               up_ack,
  output logic [IW-1:0]      owner_id,
  output logic               busy,
  output logic               to_err
);

  rr_state_e          state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_CLI-1:0] gnt_q, gnt_d;
  logic               up_req_q, up_req_d;
  logic               busy_q, busy_d;

  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic [IW-1:0]      owner_nxt;
  logic               wd_fire;

  c3lib_rr_pick #(
    .NUM_CLI (NUM_CLI),
    .IW      (IW)
  ) u_pick (
    .req_i (cli_req),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  // pointer value that puts the current owner last in the next search
  assign owner_nxt = (owner_q == IW'(NUM_CLI-1)) ? '0 : owner_q + IW'(1);

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
`ifdef C3LIB_RR_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES+1) : 1;

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          to_err_q, to_err_d;
  logic          wd_run;

  assign wd_run  = (state_q == REQ) || (state_q == REL);
  // counter holds cycles already spent in this state, so the TO_CYCLES-th
  // cycle is the one that fires
  assign wd_fire = wd_run && (wd_cnt_q == CW'(TO_CYCLES-1));

  always_comb begin
    wd_cnt_d = '0;
    to_err_d = to_err_q | wd_fire;
    // restart on every state change so REQ and REL each get a full budget
    if (wd_run && (state_d == state_q)) wd_cnt_d = wd_cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign to_err = to_err_q;
`else
  assign wd_fire = 1'b0;
  assign to_err  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;

    unique case (state_q)
      IDLE: begin
        // up_ack is deliberately ignored here
        if (pick_vld) begin
          owner_d = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (up_ack) state_d = cli_req[owner_q] ? GRANT : REL;
      end
      GRANT: begin
        if (!cli_req[owner_q]) state_d = REL;
      end
      REL: begin
        if (!up_ack) begin
          state_d  = IDLE;
          rr_ptr_d = owner_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wd_fire) begin
      state_d  = IDLE;
      rr_ptr_d = owner_nxt;
    end
  end

  // outputs decoded from the next state so they are clean flops
  always_comb begin
    up_req_d = (state_d == REQ) || (state_d == GRANT);
    busy_d   = (state_d != IDLE);
    gnt_d    = '0;
    if (state_d == GRANT) gnt_d[owner_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      up_req_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      up_req_q <= up_req_d;
      busy_q   <= busy_d;
    end
  end

  assign cli_gnt  = gnt_q;
  assign up_req   = up_req_q;
  assign owner_id = owner_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_c3lib_rr_arb_split.sv
// ---------------------------------------------------------------------------
// tb_c3lib_rr_arb_split
//   Self-checking bench for c3lib_rr_arb_split (NUM_CLI=4, TO_CYCLES=8).
//   Expected grant owners are queued when requests are driven; a negedge
//   monitor pops and compares on every new grant.
// ---------------------------------------------------------------------------
module tb_c3lib_rr_arb_split;

  localparam int N = 4;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] cli_req = '0;
  logic         up_ack  = 1'b0;
  logic [N-1:0] cli_gnt;
  logic         up_req;
  logic [1:0]   owner_id;
  logic         busy;
  logic         to_err;

  int checks   = 0;
  int failures = 0;
  int sb[$];
  int gcnt     = 0;

  always #5 clk = ~clk;

  c3lib_rr_arb_split #(
    .NUM_CLI   (N),
    .TO_CYCLES (8)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cli_req  (cli_req),
    .cli_gnt  (cli_gnt),
    .up_req   (up_req),
    .up_ack   (up_ack),
    .owner_id (owner_id),
    .busy     (busy),
    .to_err   (to_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cli_req = '0;
    up_ack  = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // grant monitor: order, owner_id and the IDLE gap before each grant
  logic [N-1:0] prev_gnt = '0;
  logic         saw_idle = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gnt = '0;
      saw_idle = 1'b1;
    end else begin
      if (cli_gnt != '0 && prev_gnt == '0) begin
        gcnt++;
        if (sb.size() == 0) chk("sb_underflow", 32'(cli_gnt), 32'd0);
        else begin
          int e;
          logic [N-1:0] eg;
          e  = sb.pop_front();
          eg = '0;
          eg[e] = 1'b1;
          chk("gnt_vec", 32'(cli_gnt), 32'(eg));
          chk("gnt_owner", 32'(owner_id), 32'(e));
        end
        chk("gnt_gap", 32'(saw_idle), 32'd1);
        saw_idle = 1'b0;
      end
      if (!busy) saw_idle = 1'b1;
      prev_gnt = cli_gnt;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int g0;
    // reset state
    #12;
    chk("rst_gnt", 32'(cli_gnt), 32'd0);
    chk("rst_upreq", 32'(up_req), 32'd0);
    chk("rst_owner", 32'(owner_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_toerr", 32'(to_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // spurious ack in IDLE
    up_ack = 1'b1;
    repeat (3) tick();
    chk("t6_upreq", 32'(up_req), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_gnt", 32'(cli_gnt), 32'd0);
    chk("t6_owner", 32'(owner_id), 32'd0);
    up_ack = 1'b0;
    tick();

    // single request from client 2
    cli_req = 4'b0100;
    sb.push_back(2);
    tick();
    chk("t1_upreq", 32'(up_req), 32'd1);
    chk("t1_owner", 32'(owner_id), 32'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_nogrant", 32'(cli_gnt), 32'd0);
    tick();
    up_ack = 1'b1;
    tick();
    chk("t1_gnt", 32'(cli_gnt), 32'b0100);
    cli_req = '0;
    tick();
    chk("t1_upreq_fall", 32'(up_req), 32'd0);
    chk("t1_gnt_fall", 32'(cli_gnt), 32'd0);
    chk("t1_busy_rel", 32'(busy), 32'd1);
    up_ack = 1'b0;
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // fairness: all clients request, ack follows up_req
    do_reset();
    foreach (sb[i]) chk("sb_leftover", 32'd1, 32'd0);
    sb.delete();
    sb.push_back(0); sb.push_back(1); sb.push_back(2);
    sb.push_back(3); sb.push_back(0); sb.push_back(1);
    g0 = gcnt;
    for (int c = 0; c < 200 && gcnt < g0 + 6; c++) begin
      cli_req = ~cli_gnt;
      up_ack  = up_req;
      tick();
    end
    cli_req = '0;
    for (int c = 0; c < 20 && (busy || up_ack); c++) begin
      up_ack = up_req;
      tick();
    end
    chk("t2_grants", 32'(gcnt - g0), 32'd6);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_idle", 32'(busy), 32'd0);

    // withdraw before ack
    do_reset();
    cli_req = 4'b0010;
    tick();
    chk("t3_owner", 32'(owner_id), 32'd1);
    cli_req = '0;
    tick();
    chk("t3_upreq", 32'(up_req), 32'd1);
    chk("t3_nogrant", 32'(cli_gnt), 32'd0);
    up_ack = 1'b1;
    tick();
    chk("t3_rel_upreq", 32'(up_req), 32'd0);
    chk("t3_rel_busy", 32'(busy), 32'd1);
    chk("t3_rel_gnt", 32'(cli_gnt), 32'd0);
    up_ack = 1'b0;
    tick();
    chk("t3_idle", 32'(busy), 32'd0);
    cli_req = 4'b1111;
    sb.push_back(2);
    tick();
    chk("t3_ptr2", 32'(owner_id), 32'd2);
    up_ack = 1'b1;
    tick();
    cli_req = '0;
    tick();
    up_ack = 1'b0;
    tick();

    // reset mid-GRANT
    do_reset();
    cli_req = 4'b0001;
    sb.push_back(0);
    tick();
    up_ack = 1'b1;
    tick();
    chk("t4_gnt", 32'(cli_gnt), 32'b0001);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_async_gnt", 32'(cli_gnt), 32'd0);
    chk("t4_async_upreq", 32'(up_req), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_owner", 32'(owner_id), 32'd0);
    cli_req = '0;
    up_ack  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cli_req = 4'b1111;
    sb.push_back(0);
    tick();
    chk("t4_ptr0", 32'(owner_id), 32'd0);
    up_ack = 1'b1;
    tick();
    cli_req = '0;
    tick();
    up_ack = 1'b0;
    tick();
    chk("t4_idle", 32'(busy), 32'd0);

`ifdef C3LIB_RR_ARB_TIMEOUT_EN
    // watchdog: up_ack never comes
    do_reset();
    cli_req = 4'b0001;
    tick();
    chk("t5_upreq", 32'(up_req), 32'd1);
    repeat (7) tick();
    chk("t5_upreq_8th", 32'(up_req), 32'd1);
    chk("t5_noerr_yet", 32'(to_err), 32'd0);
    tick();
    chk("t5_upreq_drop", 32'(up_req), 32'd0);
    chk("t5_toerr", 32'(to_err), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    cli_req = 4'b1111;
    sb.push_back(1);
    tick();
    chk("t5_next_owner", 32'(owner_id), 32'd1);
    up_ack = 1'b1;
    tick();
    cli_req = '0;
    tick();
    up_ack = 1'b0;
    tick();
    chk("t5_sticky", 32'(to_err), 32'd1);
`else
    chk("to_err_tied", 32'(to_err), 32'd0);
`endif

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
